// File: rtl/baccarat_datapath.sv
// ============================================================================
// Module      : baccarat_datapath
// Description : Baccarat card-dealing and scoring datapath driven by load strobes
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module baccarat_datapath #(
  parameter int SEED = 1
) (
  input  logic       slow_clock,
  input  logic       reset,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [2:0] cards_dealt,
  output logic       load_error
);

  localparam logic [3:0] c_seed = (SEED >= 1 && SEED <= 13) ? SEED[3:0] : 4'd1;
  localparam logic [2:0] c_max_dealt = 3'd6;

  logic [3:0] deck_q, deck_d;
  logic [3:0] slot_q [6];
  logic [3:0] slot_d [6];
  logic [2:0] dealt_q, dealt_d;
  logic       err_q, err_d;

  logic [5:0] w_load;
  logic [5:0] w_grant;
  logic       w_found;
  logic       w_multi;
  logic       w_overwrite;
  logic [4:0] w_psum, w_dsum;

  // Bit 0 is the highest-priority slot (player card 1).
  assign w_load  = {load_dcard3, load_dcard2, load_dcard1,
                    load_pcard3, load_pcard2, load_pcard1};
  assign w_multi = (w_load & (w_load - 6'd1)) != 6'd0;
  assign deck_d  = (deck_q == 4'd13) ? 4'd1 : deck_q + 4'd1;

  always_comb begin
    w_grant     = '0;
    w_found     = 1'b0;
    w_overwrite = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (w_load[i] && !w_found) begin
        w_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < 6; i++) begin
      slot_d[i] = w_grant[i] ? deck_q : slot_q[i];
      if (w_grant[i] && slot_q[i] != 4'd0) begin
        w_overwrite = 1'b1;
      end
    end
  end

  assign dealt_d = (w_found && dealt_q != c_max_dealt) ? dealt_q + 3'd1 : dealt_q;
  assign err_d   = err_q | w_multi | w_overwrite;

  always_ff @(posedge slow_clock) begin
    if (reset) begin
      deck_q  <= c_seed;
      dealt_q <= '0;
      err_q   <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        slot_q[i] <= '0;
      end
    end else begin
      deck_q  <= deck_d;
      dealt_q <= dealt_d;
      err_q   <= err_d;
      for (int i = 0; i < 6; i++) begin
        slot_q[i] <= slot_d[i];
      end
    end
  end

  function automatic logic [4:0] card_val(input logic [3:0] c);
    return (c <= 4'd9) ? {1'b0, c} : 5'd0;
  endfunction

  // Sum is at most 27, so two conditional subtractions complete the mod 10.
  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] r;
    if (s >= 5'd20)      r = s - 5'd20;
    else if (s >= 5'd10) r = s - 5'd10;
    else                 r = s;
    return r[3:0];
  endfunction

  assign w_psum = card_val(slot_q[0]) + card_val(slot_q[1]) + card_val(slot_q[2]);
  assign w_dsum = card_val(slot_q[3]) + card_val(slot_q[4]) + card_val(slot_q[5]);

  assign pcard1      = slot_q[0];
  assign pcard2      = slot_q[1];
  assign pcard3      = slot_q[2];
  assign dcard1      = slot_q[3];
  assign dcard2      = slot_q[4];
  assign dcard3      = slot_q[5];
  assign pscore      = mod10(w_psum);
  assign dscore      = mod10(w_dsum);
  assign cards_dealt = dealt_q;
  assign load_error  = err_q;

endmodule

`default_nettype wire

// File: tb/tb_baccarat_datapath.sv
// ============================================================================
// Module      : tb_baccarat_datapath
// Description : Directed self-checking bench; one datapath instance per seed
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_baccarat_datapath;

  logic       clk;
  logic       rst;
  // Strobe order per instance: {d3,d2,d1,p3,p2,p1}
  logic [5:0] ld [6];
  logic [3:0] pc1 [6];
  logic [3:0] pc2 [6];
  logic [3:0] pc3 [6];
  logic [3:0] dc1 [6];
  logic [3:0] dc2 [6];
  logic [3:0] dc3 [6];
  logic [3:0] ps  [6];
  logic [3:0] ds  [6];
  logic [2:0] cd  [6];
  logic       er  [6];

  int n_chk  = 0;
  int n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  baccarat_datapath #(.SEED(1)) u0 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[0][0]), .load_pcard2(ld[0][1]), .load_pcard3(ld[0][2]),
    .load_dcard1(ld[0][3]), .load_dcard2(ld[0][4]), .load_dcard3(ld[0][5]),
    .pcard1(pc1[0]), .pcard2(pc2[0]), .pcard3(pc3[0]),
    .dcard1(dc1[0]), .dcard2(dc2[0]), .dcard3(dc3[0]),
    .pscore(ps[0]), .dscore(ds[0]), .cards_dealt(cd[0]), .load_error(er[0]));

  baccarat_datapath #(.SEED(10)) u1 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[1][0]), .load_pcard2(ld[1][1]), .load_pcard3(ld[1][2]),
    .load_dcard1(ld[1][3]), .load_dcard2(ld[1][4]), .load_dcard3(ld[1][5]),
    .pcard1(pc1[1]), .pcard2(pc2[1]), .pcard3(pc3[1]),
    .dcard1(dc1[1]), .dcard2(dc2[1]), .dcard3(dc3[1]),
    .pscore(ps[1]), .dscore(ds[1]), .cards_dealt(cd[1]), .load_error(er[1]));

  baccarat_datapath #(.SEED(7)) u2 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[2][0]), .load_pcard2(ld[2][1]), .load_pcard3(ld[2][2]),
    .load_dcard1(ld[2][3]), .load_dcard2(ld[2][4]), .load_dcard3(ld[2][5]),
    .pcard1(pc1[2]), .pcard2(pc2[2]), .pcard3(pc3[2]),
    .dcard1(dc1[2]), .dcard2(dc2[2]), .dcard3(dc3[2]),
    .pscore(ps[2]), .dscore(ds[2]), .cards_dealt(cd[2]), .load_error(er[2]));

  baccarat_datapath #(.SEED(13)) u3 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[3][0]), .load_pcard2(ld[3][1]), .load_pcard3(ld[3][2]),
    .load_dcard1(ld[3][3]), .load_dcard2(ld[3][4]), .load_dcard3(ld[3][5]),
    .pcard1(pc1[3]), .pcard2(pc2[3]), .pcard3(pc3[3]),
    .dcard1(dc1[3]), .dcard2(dc2[3]), .dcard3(dc3[3]),
    .pscore(ps[3]), .dscore(ds[3]), .cards_dealt(cd[3]), .load_error(er[3]));

  baccarat_datapath #(.SEED(1)) u4 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[4][0]), .load_pcard2(ld[4][1]), .load_pcard3(ld[4][2]),
    .load_dcard1(ld[4][3]), .load_dcard2(ld[4][4]), .load_dcard3(ld[4][5]),
    .pcard1(pc1[4]), .pcard2(pc2[4]), .pcard3(pc3[4]),
    .dcard1(dc1[4]), .dcard2(dc2[4]), .dcard3(dc3[4]),
    .pscore(ps[4]), .dscore(ds[4]), .cards_dealt(cd[4]), .load_error(er[4]));

  // Out-of-range seed falls back to 1.
  baccarat_datapath #(.SEED(0)) u5 (
    .slow_clock(clk), .reset(rst),
    .load_pcard1(ld[5][0]), .load_pcard2(ld[5][1]), .load_pcard3(ld[5][2]),
    .load_dcard1(ld[5][3]), .load_dcard2(ld[5][4]), .load_dcard3(ld[5][5]),
    .pcard1(pc1[5]), .pcard2(pc2[5]), .pcard3(pc3[5]),
    .dcard1(dc1[5]), .dcard2(dc2[5]), .dcard3(dc3[5]),
    .pscore(ps[5]), .dscore(ds[5]), .cards_dealt(cd[5]), .load_error(er[5]));

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_loads();
    for (int i = 0; i < 6; i++) ld[i] = 6'b0;
  endtask

  initial begin
    rst = 1'b1;
    clear_loads();
    tick();
    tick();

    for (int i = 0; i < 6; i++) begin
      chk($sformatf("rst_cards_u%0d", i),
          {4'd0, pc1[i] | pc2[i] | pc3[i] | dc1[i] | dc2[i] | dc3[i]}, 8'd0);
      chk($sformatf("rst_scores_u%0d", i), {ps[i], ds[i]}, 8'd0);
      chk($sformatf("rst_dealt_u%0d", i), {5'd0, cd[i]}, 8'd0);
      chk($sformatf("rst_err_u%0d", i), {7'd0, er[i]}, 8'd0);
    end

    // Edge 1
    rst = 1'b0;
    ld[0] = 6'b000001;           // p1
    ld[1] = 6'b000001;           // p1
    ld[2] = 6'b000001;           // p1
    ld[3] = 6'b001000;           // d1
    ld[4] = 6'b001001;           // p1 + d1 together
    ld[5] = 6'b000001;           // p1
    tick();
    chk("u0_e1_pcard1", {4'd0, pc1[0]}, 8'd1);
    chk("u0_e1_pscore", {4'd0, ps[0]}, 8'd1);
    chk("u4_e1_pcard1", {4'd0, pc1[4]}, 8'd1);
    chk("u4_e1_dcard1", {4'd0, dc1[4]}, 8'd0);
    chk("u4_e1_dealt", {5'd0, cd[4]}, 8'd1);
    chk("u4_e1_err", {7'd0, er[4]}, 8'd1);
    chk("u5_badseed_pcard1", {4'd0, pc1[5]}, 8'd1);
    chk("u5_e1_err", {7'd0, er[5]}, 8'd0);

    // Edge 2
    ld[0] = 6'b001000;           // d1
    ld[1] = 6'b000010;           // p2
    ld[2] = 6'b000010;           // p2
    ld[3] = 6'b010000;           // d2
    ld[4] = 6'b000001;           // p1 again
    ld[5] = 6'b000010;           // p2, held for two edges
    tick();
    chk("u2_e2_pscore", {4'd0, ps[2]}, 8'd5);
    chk("u3_e2_dcard1", {4'd0, dc1[3]}, 8'd13);
    chk("u3_e2_dcard2", {4'd0, dc2[3]}, 8'd1);
    chk("u3_e2_dscore", {4'd0, ds[3]}, 8'd1);
    chk("u4_e2_pcard1", {4'd0, pc1[4]}, 8'd2);
    chk("u4_e2_dealt", {5'd0, cd[4]}, 8'd2);
    chk("u4_e2_err", {7'd0, er[4]}, 8'd1);

    // Edge 3
    ld[0] = 6'b000010;           // p2
    ld[1] = 6'b000100;           // p3
    ld[2] = 6'b000100;           // p3
    ld[3] = 6'b000000;
    ld[4] = 6'b000000;
    tick();
    chk("u1_e3_pcard1", {4'd0, pc1[1]}, 8'd10);
    chk("u1_e3_pcard2", {4'd0, pc2[1]}, 8'd11);
    chk("u1_e3_pcard3", {4'd0, pc3[1]}, 8'd12);
    chk("u1_e3_pscore", {4'd0, ps[1]}, 8'd0);
    chk("u2_e3_pcard3", {4'd0, pc3[2]}, 8'd9);
    chk("u2_e3_pscore", {4'd0, ps[2]}, 8'd4);
    chk("u5_held_pcard2", {4'd0, pc2[5]}, 8'd3);
    chk("u5_held_dealt", {5'd0, cd[5]}, 8'd3);
    chk("u5_held_err", {7'd0, er[5]}, 8'd1);

    // Edge 4
    ld[0] = 6'b010000;           // d2
    ld[1] = 6'b000000;
    ld[2] = 6'b000000;
    ld[5] = 6'b000100;           // p3, held through edge 7
    tick();
    chk("u0_e4_pcard1", {4'd0, pc1[0]}, 8'd1);
    chk("u0_e4_dcard1", {4'd0, dc1[0]}, 8'd2);
    chk("u0_e4_pcard2", {4'd0, pc2[0]}, 8'd3);
    chk("u0_e4_dcard2", {4'd0, dc2[0]}, 8'd4);
    chk("u0_e4_pscore", {4'd0, ps[0]}, 8'd4);
    chk("u0_e4_dscore", {4'd0, ds[0]}, 8'd6);
    chk("u0_e4_dealt", {5'd0, cd[0]}, 8'd4);
    chk("u0_e4_err", {7'd0, er[0]}, 8'd0);

    ld[0] = 6'b000000;
    tick();
    chk("u5_e5_dealt", {5'd0, cd[5]}, 8'd5);
    tick();
    tick();
    chk("u5_sat_dealt", {5'd0, cd[5]}, 8'd6);
    chk("u5_e7_pcard3", {4'd0, pc3[5]}, 8'd7);
    chk("u5_e7_pscore", {4'd0, ps[5]}, 8'd1);

    // Reset mid-hand collides with a dealer-3 strobe.
    clear_loads();
    rst   = 1'b1;
    ld[0] = 6'b100000;
    tick();
    chk("mid_rst_dcard3", {4'd0, dc3[0]}, 8'd0);
    chk("mid_rst_cards", {4'd0, pc1[0] | pc2[0] | pc3[0] | dc1[0] | dc2[0]}, 8'd0);
    chk("mid_rst_scores", {ps[0], ds[0]}, 8'd0);
    chk("mid_rst_dealt", {5'd0, cd[0]}, 8'd0);
    chk("mid_rst_err", {7'd0, er[0]}, 8'd0);
    chk("mid_rst_err_u4", {7'd0, er[4]}, 8'd0);

    rst   = 1'b0;
    ld[0] = 6'b000001;
    ld[2] = 6'b000001;
    tick();
    chk("post_rst_u0_pcard1", {4'd0, pc1[0]}, 8'd1);
    chk("post_rst_u0_dealt", {5'd0, cd[0]}, 8'd1);
    chk("post_rst_u2_pcard1", {4'd0, pc1[2]}, 8'd7);
    chk("post_rst_u2_pscore", {4'd0, ps[2]}, 8'd7);

    clear_loads();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
